// File: rtl/pipeline_stall_ctrl.sv
// Pipeline interlock: load-use stall, taken-branch flush, and multdiv freeze with timeout.
// State | meaning:  IDLE | normal issue   BUSY | multdiv running, F/D/X frozen   DONE | multdiv released
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int TO_W       = 6,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inFD,
  input  logic [31:0]      inDX,
  input  logic             branchTaken,
  input  logic             md_ready,
  output logic             stallPC,
  output logic             stallFD,
  output logic             stallDX,
  output logic             bubbleDX,
  output logic             bubbleXM,
  output logic             flushFD,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             mdBusy,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  stateT            state, nextState;
  logic [TO_W-1:0]  toCnt, toCntNext;

  logic [4:0] fdOp, fdRd, fdRs, fdRt, fdAluOp;
  logic [4:0] dxOp, dxRd, dxAluOp;
  logic       useRs, useRt, useRd, useR30;
  logic       loadUse, isMul, isDiv;
  logic       unusedBits;

  logic rStallPC, rStallFD, rStallDX, rBubbleDX, rBubbleXM, rFlushFD;
  logic rMult, rDiv, rTimeout;

  assign fdOp    = inFD[31:27];
  assign fdRd    = inFD[26:22];
  assign fdRs    = inFD[21:17];
  assign fdRt    = inFD[16:12];
  assign fdAluOp = inFD[6:2];
  assign dxOp    = inDX[31:27];
  assign dxRd    = inDX[26:22];
  assign dxAluOp = inDX[6:2];
  assign unusedBits = ^{inFD[11:7], inFD[1:0], inDX[21:7], inDX[1:0]};

  assign useRs  = !(fdOp == OP_J || fdOp == OP_JAL || fdOp == OP_SETX || fdOp == OP_BEX);
  assign useRt  = (fdOp == OP_ALU) && (fdAluOp != ALU_SLL) && (fdAluOp != ALU_SRA);
  assign useRd  = (fdOp == OP_SW) || (fdOp == OP_BNE) || (fdOp == OP_JR) || (fdOp == OP_BLT);
  assign useR30 = (fdOp == OP_BEX);

  assign loadUse = (dxOp == OP_LW) && (dxRd != 5'd0) &&
                   ((useRs && fdRs == dxRd) || (useRt && fdRt == dxRd) ||
                    (useRd && fdRd == dxRd) || (useR30 && dxRd == 5'd30));
  assign isMul = (dxOp == OP_ALU) && (dxAluOp == ALU_MUL);
  assign isDiv = (dxOp == OP_ALU) && (dxAluOp == ALU_DIV);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      toCnt <= '0;
    end else begin
      state <= nextState;
      toCnt <= toCntNext;
    end
  end

  always_comb begin
    nextState = state;
    toCntNext = toCnt;
    rStallPC  = 1'b0;
    rStallFD  = 1'b0;
    rStallDX  = 1'b0;
    rBubbleDX = 1'b0;
    rBubbleXM = 1'b0;
    rFlushFD  = 1'b0;
    rMult     = 1'b0;
    rDiv      = 1'b0;
    rTimeout  = 1'b0;
    case (state)
      IDLE: begin
        if (branchTaken) begin
          rFlushFD  = 1'b1;
          rBubbleDX = 1'b1;
        end else if (isMul || isDiv) begin
          rMult     = isMul;
          rDiv      = isDiv;
          rStallPC  = 1'b1;
          rStallFD  = 1'b1;
          rStallDX  = 1'b1;
          rBubbleXM = 1'b1;
          toCntNext = '0;
          nextState = BUSY;
        end else if (loadUse) begin
          rStallPC  = 1'b1;
          rStallFD  = 1'b1;
          rBubbleDX = 1'b1;
        end
      end
      BUSY: begin
        rStallPC  = 1'b1;
        rStallFD  = 1'b1;
        rStallDX  = 1'b1;
        rBubbleXM = 1'b1;
        if (md_ready) begin
          nextState = DONE;
        end else if (toCnt == TO_W'(MD_TIMEOUT - 1)) begin
          rTimeout  = 1'b1;
          nextState = DONE;
        end else begin
          toCntNext = toCnt + 1'b1;
        end
      end
      DONE: begin
        // The mul/div still sits in DX this cycle, so a start here would relaunch it.
        nextState = IDLE;
        if (branchTaken) begin
          rFlushFD  = 1'b1;
          rBubbleDX = 1'b1;
        end else if (loadUse) begin
          rStallPC  = 1'b1;
          rStallFD  = 1'b1;
          rBubbleDX = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs forced low while reset is held, even though IDLE decode is combinational.
  assign stallPC   = rStallPC  & ~reset;
  assign stallFD   = rStallFD  & ~reset;
  assign stallDX   = rStallDX  & ~reset;
  assign bubbleDX  = rBubbleDX & ~reset;
  assign bubbleXM  = rBubbleXM & ~reset;
  assign flushFD   = rFlushFD  & ~reset;
  assign ctrl_MULT = rMult     & ~reset;
  assign ctrl_DIV  = rDiv      & ~reset;
  assign mdTimeout = rTimeout  & ~reset;
  assign mdBusy    = (state == BUSY) & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
    end else if (stallPC && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: hand-computed output vectors checked with immediate assertions.
module tb_pipeline_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inFD = '0;
  logic [31:0] inDX = '0;
  logic        branchTaken = 1'b0;
  logic        md_ready = 1'b0;
  logic        stallPC, stallFD, stallDX, bubbleDX, bubbleXM, flushFD;
  logic        ctrl_MULT, ctrl_DIV, mdBusy, mdTimeout;
  logic [15:0] stallCount;

  int checks = 0;
  int failures = 0;

  // Output vector order: stallPC stallFD stallDX bubbleDX bubbleXM flushFD ctrl_MULT ctrl_DIV mdBusy mdTimeout
  localparam logic [9:0] V_NONE  = 10'b0000000000;
  localparam logic [9:0] V_LU    = 10'b1101000000;
  localparam logic [9:0] V_FL    = 10'b0001010000;
  localparam logic [9:0] V_MUL   = 10'b1110101000;
  localparam logic [9:0] V_DIV   = 10'b1110100100;
  localparam logic [9:0] V_BUSY  = 10'b1110100010;
  localparam logic [9:0] V_BUSYT = 10'b1110100011;

  pipeline_stall_ctrl dut (
    .clock(clock), .reset(reset), .inFD(inFD), .inDX(inDX),
    .branchTaken(branchTaken), .md_ready(md_ready),
    .stallPC(stallPC), .stallFD(stallFD), .stallDX(stallDX),
    .bubbleDX(bubbleDX), .bubbleXM(bubbleXM), .flushFD(flushFD),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .mdBusy(mdBusy),
    .mdTimeout(mdTimeout), .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, aluop);
    return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [9:0] outVec();
    return {stallPC, stallFD, stallDX, bubbleDX, bubbleXM, flushFD,
            ctrl_MULT, ctrl_DIV, mdBusy, mdTimeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input string tag, input logic [9:0] exp);
    #1;
    chk(tag, {22'd0, outVec()}, {22'd0, exp});
  endtask

  initial begin
    int expCount;
    expCount = 0;

    // Reset: outputs low even with a branch and load-use on the inputs.
    branchTaken = 1'b1;
    inDX = mk(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00000, 5'd7, 5'd5, 5'd2, 5'd0);
    tick();
    settle("reset_outputs", V_NONE);
    chk("reset_count", {16'd0, stallCount}, 32'd0);
    branchTaken = 1'b0;
    inDX = '0;
    inFD = '0;
    reset = 1'b0;
    tick();

    // Load-use through rs, then the bubble moves through.
    inDX = mk(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00000, 5'd7, 5'd5, 5'd2, 5'd0);
    settle("lu_rs", V_LU);
    tick(); expCount++;
    inDX = '0;
    settle("lu_after", V_NONE);
    tick();
    inDX = mk(5'b01000, 5'd0, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00000, 5'd7, 5'd0, 5'd2, 5'd0);
    settle("lu_r0", V_NONE);
    tick();

    // Source-field decode.
    inDX = mk(5'b01000, 5'd3, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00111, 5'd3, 5'd9, 5'd0, 5'd0);
    settle("lu_sw_rd", V_LU);
    tick(); expCount++;
    inDX = mk(5'b01000, 5'd4, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00000, 5'd8, 5'd3, 5'd4, 5'b00100);
    settle("sll_no_rt", V_NONE);
    tick();
    inFD = mk(5'b00000, 5'd8, 5'd3, 5'd4, 5'b00000);
    settle("add_rt", V_LU);
    tick(); expCount++;
    inDX = mk(5'b01000, 5'd30, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b10110, 5'd0, 5'd0, 5'd0, 5'd0);
    settle("bex_r30", V_LU);
    tick(); expCount++;
    inDX = mk(5'b01000, 5'd4, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00001, 5'd4, 5'd4, 5'd4, 5'd0);
    settle("j_no_src", V_NONE);
    tick();

    // Branch beats load-use in IDLE.
    inDX = mk(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00000, 5'd7, 5'd5, 5'd2, 5'd0);
    branchTaken = 1'b1;
    settle("br_over_lu", V_FL);
    tick();
    branchTaken = 1'b0;
    inFD = '0;

    // mul with md_ready on the 5th BUSY cycle; branch in BUSY is ignored.
    inDX = mk(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00110);
    settle("mul_start", V_MUL);
    tick(); expCount++;
    for (int i = 1; i <= 5; i++) begin
      branchTaken = (i == 3);
      md_ready = (i == 5);
      settle($sformatf("mul_busy%0d", i), V_BUSY);
      tick(); expCount++;
    end
    branchTaken = 1'b0;
    md_ready = 1'b0;
    settle("mul_done", V_NONE);
    tick();
    inDX = '0;
    settle("mul_idle", V_NONE);
    chk("mul_count", {16'd0, stallCount}, expCount);
    tick();

    // div with no md_ready: 40 BUSY cycles, timeout on the last.
    inDX = mk(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00111);
    settle("div_start", V_DIV);
    tick(); expCount++;
    for (int i = 1; i <= 40; i++) begin
      settle($sformatf("div_busy%0d", i), (i == 40) ? V_BUSYT : V_BUSY);
      tick(); expCount++;
    end
    settle("div_done", V_NONE);
    tick();
    inDX = '0;
    settle("div_idle", V_NONE);
    chk("div_count", {16'd0, stallCount}, expCount);
    tick();

    // md_ready coinciding with the timeout cycle suppresses mdTimeout.
    inDX = mk(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00111);
    settle("div2_start", V_DIV);
    tick(); expCount++;
    for (int i = 1; i <= 40; i++) begin
      md_ready = (i == 40);
      #1;
      if (i >= 39) chk($sformatf("div2_busy%0d", i), {22'd0, outVec()}, {22'd0, V_BUSY});
      tick(); expCount++;
    end
    md_ready = 1'b0;
    settle("div2_done", V_NONE);
    chk("div2_count", {16'd0, stallCount}, expCount);
    tick();
    inDX = '0;
    tick();

    // Reset in the third BUSY cycle.
    inDX = mk(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00110);
    settle("rst_mul_start", V_MUL);
    tick();
    tick();
    tick();
    settle("rst_busy3", V_BUSY);
    reset = 1'b1;
    settle("rst_async_out", V_NONE);
    chk("rst_async_count", {16'd0, stallCount}, 32'd0);
    inDX = '0;
    #1;
    reset = 1'b0;
    settle("rst_idle", V_NONE);
    tick();
    settle("rst_idle_next", V_NONE);
    chk("rst_count_zero", {16'd0, stallCount}, 32'd0);

    // Saturation via a held load-use stall.
    inDX = mk(5'b01000, 5'd5, 5'd0, 5'd0, 5'd0);
    inFD = mk(5'b00000, 5'd7, 5'd5, 5'd2, 5'd0);
    repeat (65534) tick();
    chk("sat_below", {16'd0, stallCount}, 32'h0000FFFE);
    tick();
    chk("sat_max", {16'd0, stallCount}, 32'h0000FFFF);
    tick();
    tick();
    chk("sat_hold", {16'd0, stallCount}, 32'h0000FFFF);
    inDX = '0;
    inFD = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
